// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame scheduler: FSM state encoding,
// ASCII constants used by the line sources, and the grant helper.
package uart_frame_pkg;

    localparam int unsigned GRANT_WIDTH   = 2;
    localparam int unsigned TIMEOUT_WIDTH = 20;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_LF    = 8'h0a;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_O     = 8'h4f;
    localparam logic [7:0] ASCII_K     = 8'h4b;
    localparam logic [7:0] ASCII_X     = 8'h58;

    // One-hot grant {src1,src0} for a source select bit
    function automatic logic [GRANT_WIDTH-1:0] src_onehot(input logic sel);
        return sel ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/uart_frame_scheduler_rr_arbiter2.sv
// Two-input round-robin arbiter: a lone request wins outright, a tie goes to the
// source that was not served last. The pointer moves only when upd_en is high.
module rr_arbiter2
    import uart_frame_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [GRANT_WIDTH-1:0] req,
    input  logic                   upd_en,
    input  logic                   upd_src,
    output logic [GRANT_WIDTH-1:0] grant_c
);

    // 1 = src1 was served last, so src0 wins the first tie after reset
    logic last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (upd_en) begin
            last_q <= upd_src;
        end
    end

    always_comb begin
        grant_c = '0;
        case (req)
            2'b01:   grant_c = 2'b01;
            2'b10:   grant_c = 2'b10;
            2'b11:   grant_c = src_onehot(~last_q);
            default: grant_c = '0;
        endcase
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Shares one uart_tx between two ASCII line sources, stepping char_idx per byte.
// Optional WAIT timeout with sticky err is enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IDX_WIDTH  = 5,
    parameter int unsigned FRAME_LEN0 = 25,
    parameter int unsigned FRAME_LEN1 = 16
`ifdef UART_FRAME_TIMEOUT_EN
    ,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT = 20'd1_000_000
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   src0_req,
    input  logic                   src1_req,
    input  logic [DATA_WIDTH-1:0]  src0_data,
    input  logic [DATA_WIDTH-1:0]  src1_data,
    output logic [IDX_WIDTH-1:0]   char_idx,
    output logic [GRANT_WIDTH-1:0] grant,
    output logic                   src0_ack,
    output logic                   src1_ack,
    output logic                   tx_start,
    output logic [DATA_WIDTH-1:0]  tx_data,
    input  logic                   tx_done,
    output logic                   busy,
    output logic                   err
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX0 = IDX_WIDTH'(FRAME_LEN0 - 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX1 = IDX_WIDTH'(FRAME_LEN1 - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_d;
    logic [GRANT_WIDTH-1:0] grant_d;
    logic                   ack0_d, ack1_d;
    logic                   start_d;
    logic [DATA_WIDTH-1:0]  data_d;
    logic [GRANT_WIDTH-1:0] arb_grant;
    logic                   arb_upd;
    logic [IDX_WIDTH-1:0]   last_idx;

`ifdef UART_FRAME_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                     err_d;
`endif

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     ({src1_req, src0_req}),
        .upd_en  (arb_upd),
        .upd_src (grant[1]),
        .grant_c (arb_grant)
    );

    assign last_idx = grant[1] ? LAST_IDX1 : LAST_IDX0;

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        idx_d   = char_idx;
        grant_d = grant;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        start_d = 1'b0;
        data_d  = tx_data;
        arb_upd = 1'b0;
`ifdef UART_FRAME_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err;
`endif
        case (state_q)
            IDLE: begin
                if (arb_grant != '0) begin
                    grant_d = arb_grant;
                    idx_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                data_d  = grant[1] ? src1_data : src0_data;
                start_d = 1'b1;
                state_d = SEND;
            end
            SEND: begin
`ifdef UART_FRAME_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (tx_done) begin
                    if (char_idx == last_idx) begin
                        ack0_d  = grant[0];
                        ack1_d  = grant[1];
                        state_d = DONE;
                    end else begin
                        idx_d   = char_idx + IDX_WIDTH'(1);
                        state_d = LOAD;
                    end
                end
`ifdef UART_FRAME_TIMEOUT_EN
                else if (cnt_q == TIMEOUT - TIMEOUT_WIDTH'(1)) begin
                    ack0_d  = grant[0];
                    ack1_d  = grant[1];
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_WIDTH'(1);
                end
`endif
            end
            DONE: begin
                arb_upd = 1'b1;
                grant_d = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            char_idx <= '0;
            grant    <= '0;
            src0_ack <= 1'b0;
            src1_ack <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            char_idx <= idx_d;
            grant    <= grant_d;
            src0_ack <= ack0_d;
            src1_ack <= ack1_d;
            tx_start <= start_d;
            tx_data  <= data_d;
            busy     <= (state_d != IDLE);
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    // WAIT cycle counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            err   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err   <= err_d;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
